// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU sequential multiplier.
// Optional MULT_OVF_EN build adds a product-overflow flag (see alu_mult_seq).
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(ALU_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } mult_state_e;

endpackage

// File: rtl/alu_mult_datapath.sv
// Shift-add datapath: multiplicand/multiplier/accumulator registers.
// One multiplier bit is consumed per i_step; ACC_W > WIDTH keeps the high product bits.
module alu_mult_datapath
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned ACC_W = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [ACC_W-1:0] o_acc
);

  logic [ACC_W-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [ACC_W-1:0] r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_load) begin
      r_mcand  <= ACC_W'(i_a);
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (i_step) begin
      // Bits shifted past ACC_W are discarded, giving the modular product.
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/alu_mult_seq.sv
// Sequential unsigned multiplier: FSM, bit counter and start/busy/done handshake.
// Define MULT_OVF_EN to add the registered ovf output (upper product bits nonzero).
module alu_mult_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic             busy,
`ifdef MULT_OVF_EN
  output logic             ovf,
`endif
  output logic             done
);

  localparam int unsigned LCNT_W = cnt_width(WIDTH);
`ifdef MULT_OVF_EN
  localparam int unsigned ACC_W = 2 * WIDTH;
`else
  localparam int unsigned ACC_W = WIDTH;
`endif

  mult_state_e       r_state;
  mult_state_e       w_state_nxt;
  logic [LCNT_W-1:0] r_cnt;
  logic [LCNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]  r_c;
  logic [WIDTH-1:0]  w_c_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_load;
  logic              w_step;
  logic [ACC_W-1:0]  w_acc;
`ifdef MULT_OVF_EN
  logic              r_ovf;
  logic              w_ovf_nxt;
`endif

  alu_mult_datapath #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_datapath (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_step (w_step),
    .i_a    (A),
    .i_b    (B),
    .o_acc  (w_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_c     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef MULT_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_c     <= w_c_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef MULT_OVF_EN
      r_ovf   <= w_ovf_nxt;
`endif
    end
  end

  // Next state and next registered outputs; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_c_nxt     = r_c;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
`ifdef MULT_OVF_EN
    w_ovf_nxt   = r_ovf;
`endif
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step     = 1'b1;
        w_busy_nxt = 1'b1;
        w_cnt_nxt  = r_cnt + LCNT_W'(1);
        if (r_cnt == LCNT_W'(WIDTH - 1)) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = FINISH;
        end
      end
      FINISH: begin
        w_c_nxt     = w_acc[WIDTH-1:0];
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
`ifdef MULT_OVF_EN
        w_ovf_nxt   = |w_acc[ACC_W-1:WIDTH];
`endif
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign C    = r_c;
  assign busy = r_busy;
  assign done = r_done;
`ifdef MULT_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_alu_mult_seq.sv
// Scoreboard bench for alu_mult_seq: expected products queued at start, checked at done.
module tb_alu_mult_seq;

  localparam int unsigned W = 8;
  localparam int unsigned LAT = W + 2;

  typedef struct {
    logic [31:0] c;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] C;
  logic         busy;
  logic         done;
`ifdef MULT_OVF_EN
  logic         ovf;
`endif

  exp_t        sb_q[$];
  int          cyc;
  int          n_checks;
  int          n_errors;
  logic [31:0] model_c;
  logic        model_ovf;
  logic        exp_done;
  logic        exp_busy;

  alu_mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .C     (C),
    .busy  (busy),
`ifdef MULT_OVF_EN
    .ovf   (ovf),
`endif
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Expected done/busy timing and C value derived from the queued operations.
  always @(negedge clk) begin
    exp_done = (sb_q.size() > 0) && (sb_q[0].cyc == cyc);
    exp_busy = (sb_q.size() > 0) && (cyc >= sb_q[0].cyc - int'(W) - 1)
               && (cyc <= sb_q[0].cyc - 2);
    check("done", {31'd0, done}, {31'd0, exp_done});
    check("busy", {31'd0, busy}, {31'd0, exp_busy});
    if (exp_done) begin
      model_c   = sb_q[0].c;
      model_ovf = sb_q[0].ovf;
      void'(sb_q.pop_front());
    end
    check("C", {24'd0, C}, model_c);
`ifdef MULT_OVF_EN
    check("ovf", {31'd0, ovf}, {31'd0, model_ovf});
`endif
  end

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input int at_cyc);
    exp_t        e;
    longint unsigned p;
    p     = longint'(a) * longint'(b);
    e.c   = 32'(p % (64'd1 << W));
    e.ovf = (p >> W) != 0;
    e.cyc = at_cyc;
    sb_q.push_back(e);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    push_exp(a, b, cyc + int'(LAT));
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int exp1;
    n_checks  = 0;
    n_errors  = 0;
    model_c   = '0;
    model_ovf = 1'b0;
    start     = 1'b0;
    A         = '0;
    B         = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1;
    check("rst_C", {24'd0, C}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    do_op(8'd7, 8'd3);
    drain();
    do_op(8'd255, 8'd255);
    drain();
    do_op(8'd16, 8'd16);
    drain();
    do_op(8'd0, 8'd200);
    drain();
    do_op(8'd123, 8'd1);
    drain();

    // Abort mid-RUN: no done may follow, outputs clear at once.
    do_op(8'd100, 8'd3);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    sb_q.delete();
    model_c   = '0;
    model_ovf = 1'b0;
    #1;
    check("abort_C", {24'd0, C}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (15) @(negedge clk);

    // Start pulsed during RUN must be ignored.
    do_op(8'd5, 8'd6);
    repeat (2) @(negedge clk);
    A = 8'd9;
    B = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Start held high: back-to-back operations.
    @(negedge clk);
    A = 8'd12;
    B = 8'd10;
    start = 1'b1;
    exp1 = cyc + int'(LAT);
    push_exp(8'd12, 8'd10, exp1);
    while (cyc < exp1) @(negedge clk);
    A = 8'd2;
    B = 8'd3;
    push_exp(8'd2, 8'd3, cyc + int'(LAT));
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    drain();

    for (int i = 0; i < 6; i++) begin
      do_op(W'($urandom), W'($urandom));
      drain();
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
- Sequential unsigned shift-add multiplier for the 8-bit ALU datapath; produces the low WIDTH bits of A*B.
- Accepts operands on a start pulse, iterates one multiplier bit per clock, presents a registered result with a one-cycle done pulse.
- Sits beside the ALU's combinational units; the ALU mux selects C when the multiply opcode is active.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  multiplicand, unsigned
- B  input  WIDTH  multiplier, unsigned
- C  output  WIDTH  product low bits (A*B mod 2^WIDTH), registered
- busy  output  1  high while a multiply is in progress
- done  output  1  one-cycle pulse when C is updated

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; C=0, busy=0, done=0; internal operand/accumulator registers cleared. Deasserting mid-operation aborts the operation; no done pulse follows.
- States: IDLE, RUN, FINISH.
- IDLE: start=1 captures A into the multiplicand register and B into the multiplier shift register, clears the accumulator and count, and moves to RUN. busy rises on the next edge.
- RUN: each cycle adds the multiplicand to the accumulator if multiplier LSB=1. The multiplicand shifts left by 1 and the multiplier shifts right by 1. Accumulator is WIDTH bits; overflow beyond WIDTH is discarded.
- RUN lasts exactly WIDTH cycles, then the FSM moves to FINISH.
- FINISH: C<=accumulator, done=1 for exactly one cycle, busy=0, then IDLE.
- Latency: start sampled at edge N; done high in the cycle after edge N+WIDTH+1. Fixed at WIDTH+2 cycles from start to done, independent of operand values; no early termination.
- start while busy or in FINISH is ignored; operands are not re-sampled.
- start held high continuously launches a new operation on each IDLE cycle. Throughput is one result per WIDTH+2 cycles.
- C holds its last value between completions and changes only in the FINISH transition.
- A/B may change freely after the start cycle.
- Zero operand gives C=0. Max operands give the wrapped low bits (8-bit: 255*255 -> C=1).

Optional Feature:
- Macro MULT_OVF_EN.
- Defined: extra output ovf (1 bit). The accumulator is widened to 2*WIDTH internally. ovf is registered with C in FINISH and is 1 iff the upper WIDTH product bits are nonzero. It resets to 0 and holds between completions.
- Undefined: no ovf port; the accumulator is WIDTH bits. C behaviour is identical in both builds.

Decomposition:
- Shared package alu_pkg: WIDTH default constant, FSM state typedef (IDLE, RUN, FINISH), and a counter-width constant of $clog2(WIDTH+1).
- One natural sub-module: alu_mult_datapath (operand/accumulator registers, conditional add, shifts). alu_mult_seq keeps the FSM, counter and handshake.

Test Plan:
- Reset mid-RUN: assert rst_n=0 during cycle 3 of RUN -> C=0, busy=0, done=0 immediately. After release, no done pulse until a new start.
- Basic: A=7, B=3, start pulse -> done after 10 cycles, C=21, busy low after done. With MULT_OVF_EN, ovf=0.
- Wrap: A=255, B=255 -> C=1. With MULT_OVF_EN, ovf=1. Also A=16, B=16 -> C=0; with MULT_OVF_EN, ovf=1.
- Zero/identity: A=0, B=200 -> C=0. A=123, B=1 -> C=123. Latency is 10 cycles in both cases.
- Start ignored while busy: start A=5, B=6, then pulse start with A=9, B=9 during RUN -> single done, C=30. busy continuous.
- Back-to-back: start held high with A=12, B=10, then A=2, B=3 -> done pulses 10 cycles apart; C=120, then C=6. C is stable between pulses.
